// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch outcome codes, branch opcodes and the
// redirect FSM state encoding.
package cpu_pkg;

  // Comparator outcome codes
  localparam logic [1:0] BR_NONE      = 2'b00;
  localparam logic [1:0] BR_NOT_TAKEN = 2'b01;
  localparam logic [1:0] BR_TAKEN     = 2'b10;
  localparam logic [1:0] BR_RSVD      = 2'b11;

  // Branch opcodes decoded upstream of the comparator
  localparam logic [3:0] OP_BGT = 4'b0100;
  localparam logic [3:0] OP_BLT = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b0110;

  // Flush window counter width (FLUSH_CYCLES is limited to 0..15)
  localparam int FCNT_W = 4;

  // Redirect FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REDIRECT = 2'b01,
    ST_FLUSH    = 2'b10
  } redir_state_e;

endpackage

// File: rtl/branch_redirect_unit_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count up on inc until all-ones, then hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (inc && (r_count != {W{1'b1}}))
      r_count <= r_count + W'(1);
  end

  assign count = r_count;

endmodule

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: turns decode-stage branch outcomes into a fetch
// redirect handshake plus a flush window, and keeps branch statistics.
module branch_redirect_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int OFF_W        = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [OFF_W-1:0]  id_offset,
  input  logic [1:0]        branch,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  not_taken_cnt,
  output logic              bad_code
);

  // Counter preload on accept; only meaningful when FLUSH_CYCLES > 0
  localparam logic [FCNT_W-1:0] FC_LOAD =
    (FLUSH_CYCLES > 0) ? FCNT_W'(FLUSH_CYCLES - 1) : '0;

  redir_state_e      r_state;
  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic              r_flush;
  logic              r_busy;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_bad_code;

  logic              w_sample;
  logic              w_taken;
  logic              w_not_taken;
  logic [ADDR_W-1:0] w_off_ext;
  logic [ADDR_W-1:0] w_target;

  // Decode inputs are only looked at while idle; a busy unit drops them
  assign w_sample    = (r_state == ST_IDLE) && id_valid;
  assign w_taken     = w_sample && (branch == BR_TAKEN);
  assign w_not_taken = w_sample && (branch == BR_NOT_TAKEN);

  // Offset counts 2-byte instructions; target wraps modulo 2^ADDR_W
  assign w_off_ext = ADDR_W'($signed(id_offset));
  assign w_target  = id_pc + ADDR_W'(2) + (w_off_ext << 1);

  // Redirect FSM with registered handshake/flush/busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_busy           <= 1'b0;
      r_fcnt           <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_taken) begin
            r_redirect_pc    <= w_target;
            r_redirect_valid <= 1'b1;
            r_flush          <= 1'b1;
            r_busy           <= 1'b1;
            r_state          <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
            if (FLUSH_CYCLES > 0) begin
              r_fcnt  <= FC_LOAD;
              r_state <= ST_FLUSH;
            end else begin
              r_flush <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (r_fcnt == '0) begin
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_fcnt <= r_fcnt - FCNT_W'(1);
          end
        end
        default: begin
          r_redirect_valid <= 1'b0;
          r_flush          <= 1'b0;
          r_busy           <= 1'b0;
          r_state          <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flag for the reserved outcome code; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bad_code <= 1'b0;
    else if (w_sample && (branch == BR_RSVD))
      r_bad_code <= 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_taken),
    .count (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_not_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_not_taken),
    .count (not_taken_cnt)
  );

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign busy           = r_busy;
  assign bad_code       = r_bad_code;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Bench for branch_redirect_unit: directed scenarios then random traffic,
// every cycle compared against a cycle-count model of the unit's behaviour.
module tb_branch_redirect_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [7:0]  id_offset;
  logic [1:0]  branch;
  logic        redirect_ready;

  logic        redirect_valid, flush, busy, bad_code;
  logic [15:0] redirect_pc, taken_cnt, not_taken_cnt;

  // Narrow-counter instance sharing the same stimulus
  logic        n_redirect_valid, n_flush, n_busy, n_bad_code;
  logic [15:0] n_redirect_pc;
  logic [1:0]  n_taken_cnt, n_not_taken_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int          m_taken, m_nt;
  bit          m_bad, m_wait;
  int          m_left;
  logic [15:0] m_target;

  always #5 clk = ~clk;

  branch_redirect_unit #(.ADDR_W(16), .OFF_W(8), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_offset(id_offset), .branch(branch), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
    .busy(busy), .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt),
    .bad_code(bad_code)
  );

  branch_redirect_unit #(.ADDR_W(16), .OFF_W(8), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_offset(id_offset), .branch(branch), .redirect_valid(n_redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(n_redirect_pc), .flush(n_flush),
    .busy(n_busy), .taken_cnt(n_taken_cnt), .not_taken_cnt(n_not_taken_cnt),
    .bad_code(n_bad_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_taken = 0; m_nt = 0; m_bad = 0; m_wait = 0; m_left = 0; m_target = '0;
  endtask

  // One clock edge of the intended behaviour, from the sampled inputs
  task automatic model_edge();
    int t;
    if (!rst_n) begin
      model_reset();
    end else if (m_wait) begin
      if (redirect_ready) begin
        m_wait = 0;
        m_left = FC;
      end
    end else if (m_left > 0) begin
      m_left--;
    end else if (id_valid) begin
      case (branch)
        2'b10: begin
          t = int'(id_pc) + 2 + 2 * int'($signed(id_offset));
          m_target = t[15:0];
          if (m_taken < 65535) m_taken++;
          m_wait = 1;
        end
        2'b01: if (m_nt < 65535) m_nt++;
        2'b11: m_bad = 1;
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    bit m_busy;
    m_busy = m_wait || (m_left > 0);
    chk("redirect_valid", 32'(redirect_valid), 32'(m_wait));
    chk("flush",          32'(flush),          32'(m_busy));
    chk("busy",           32'(busy),           32'(m_busy));
    chk("redirect_pc",    32'(redirect_pc),    32'(m_target));
    chk("taken_cnt",      32'(taken_cnt),      32'(m_taken));
    chk("not_taken_cnt",  32'(not_taken_cnt),  32'(m_nt));
    chk("bad_code",       32'(bad_code),       32'(m_bad));
    chk("sat_taken_cnt",  32'(n_taken_cnt),    32'((m_taken > 3) ? 3 : m_taken));
    chk("sat_nt_cnt",     32'(n_not_taken_cnt), 32'((m_nt > 3) ? 3 : m_nt));
    chk("sat_busy",       32'(n_busy),         32'(m_busy));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [1:0] b, input logic [15:0] pc,
                       input logic [7:0] off);
    id_valid = v; branch = b; id_pc = pc; id_offset = off;
  endtask

  initial begin
    int cf, cv;
    rst_n = 1'b0;
    redirect_ready = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 8'h0);
    model_reset();
    #1;
    check_all();
    step(); step();
    rst_n = 1'b1;
    step();

    // Not-taken x3: counter only, never busy
    drive(1'b1, 2'b01, 16'h0010, 8'h00);
    repeat (3) step();
    drive(1'b0, 2'b00, 16'h0, 8'h0);
    step();
    chk("nt_three", 32'(not_taken_cnt), 32'd3);

    // Taken, ready tied high
    redirect_ready = 1'b1;
    drive(1'b1, 2'b10, 16'h0040, 8'h05);
    step();
    drive(1'b0, 2'b00, 16'h0, 8'h0);
    chk("fwd_target", 32'(redirect_pc), 32'h004C);
    cf = int'(flush); cv = int'(redirect_valid);
    repeat (5) begin
      step();
      cf += int'(flush); cv += int'(redirect_valid);
    end
    chk("fwd_flush_len", 32'(cf), 32'd3);
    chk("fwd_valid_len", 32'(cv), 32'd1);
    chk("fwd_taken", 32'(taken_cnt), 32'd1);

    // Backward taken, ready held low for 4 edges, second branch ignored
    redirect_ready = 1'b0;
    drive(1'b1, 2'b10, 16'h0004, 8'hFC);
    step();
    chk("bwd_target", 32'(redirect_pc), 32'hFFFE);
    drive(1'b1, 2'b10, 16'h0100, 8'h10);
    cv = 1;
    repeat (4) begin
      step();
      cv += int'(redirect_valid && redirect_pc == 16'hFFFE);
    end
    chk("bwd_stable", 32'(cv), 32'd5);
    redirect_ready = 1'b1;
    drive(1'b0, 2'b00, 16'h0, 8'h0);
    repeat (4) step();
    chk("bwd_taken", 32'(taken_cnt), 32'd2);

    // Reserved code: sticky flag, counters untouched
    drive(1'b1, 2'b11, 16'h0200, 8'h01);
    step();
    drive(1'b0, 2'b00, 16'h0, 8'h0);
    repeat (10) step();
    chk("rsvd_flag", 32'(bad_code), 32'd1);
    chk("rsvd_taken", 32'(taken_cnt), 32'd2);
    chk("rsvd_nt", 32'(not_taken_cnt), 32'd3);

    // Asynchronous reset while in the flush window
    drive(1'b1, 2'b10, 16'h0080, 8'h10);
    step();
    drive(1'b0, 2'b00, 16'h0, 8'h0);
    step();
    chk("mid_flush", 32'(flush && !redirect_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 2'b10, 16'h0040, 8'h05);
    step();
    drive(1'b0, 2'b00, 16'h0, 8'h0);
    chk("post_rst_target", 32'(redirect_pc), 32'h004C);
    cf = int'(flush);
    repeat (5) begin
      step();
      cf += int'(flush);
    end
    chk("post_rst_flush_len", 32'(cf), 32'd3);

    // Saturation on the narrow instance: 5 taken branches
    repeat (5) begin
      drive(1'b1, 2'b10, 16'h1000, 8'h7F);
      step();
      drive(1'b0, 2'b00, 16'h0, 8'h0);
      repeat (3) step();
    end
    chk("sat_hold", 32'(n_taken_cnt), 32'd3);
    chk("wide_taken", 32'(taken_cnt), 32'd6);

    // Random traffic
    rst_n = 1'b0;
    #1;
    model_reset();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
            16'($urandom), 8'($urandom));
      redirect_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Consumes the 2-bit branch outcome produced by the comparator in the decode stage and acts on it. On a taken branch it computes the target PC, presents it to fetch over a valid/ready handshake, and flushes the younger pipeline stages for a fixed number of cycles. It also keeps saturating taken and not-taken statistics and flags reserved outcome codes. It sits between the decode-stage comparator and the fetch-stage PC mux.

## Interface
- `ADDR_W`, default 16: PC width.
- `OFF_W`, default 8: branch offset field width, in instructions, signed.
- `FLUSH_CYCLES`, default 2: cycles `flush` stays high after the redirect is accepted; legal range 0..15.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `id_valid`, in, 1: the decode stage holds a valid instruction this cycle.
- `id_pc`, in, `ADDR_W`: byte address of that instruction.
- `id_offset`, in, `OFF_W`: signed branch offset in instructions.
- `branch`, in, 2: comparator outcome. 00 = not a branch, 01 = branch not taken, 10 = branch taken, 11 = reserved.
- `redirect_valid`, out, 1: `redirect_pc` is valid for fetch.
- `redirect_ready`, in, 1: fetch accepts the redirect.
- `redirect_pc`, out, `ADDR_W`: branch target.
- `flush`, out, 1: squash the IF and ID stage contents.
- `busy`, out, 1: the unit is servicing a branch; decode must stall.
- `taken_cnt`, out, `CNT_W`: saturating count of taken branches.
- `not_taken_cnt`, out, `CNT_W`: saturating count of not-taken branches.
- `bad_code`, out, 1: sticky; set when outcome 11 is seen.

## Operation
- FSM states:
  - IDLE: waiting for a branch outcome.
  - REDIRECT: presenting the target to fetch.
  - FLUSH: counting out the flush window.
- IDLE transitions, evaluated only when `id_valid`=1:
  - `branch`=10:
    - Register `redirect_pc` = `id_pc` + 2 + (sext(`id_offset`) << 1), truncated to `ADDR_W` so the result wraps modulo 2^`ADDR_W`.
    - Increment `taken_cnt`.
    - Go to REDIRECT.
  - `branch`=01: increment `not_taken_cnt` and stay in IDLE.
  - `branch`=00: no action.
  - `branch`=11: set `bad_code`, treat as not taken, increment no counter, stay in IDLE.
  - With `id_valid`=0, `branch` is ignored.
- REDIRECT: hold `redirect_valid`=1 and `redirect_pc` stable until `redirect_ready` is sampled high.
  - If `FLUSH_CYCLES`>0, go to FLUSH and load the down-counter with `FLUSH_CYCLES`-1.
  - If `FLUSH_CYCLES`=0, go to IDLE.
- FLUSH: decrement the counter each cycle; leave for IDLE after the cycle in which the counter is 0.
- Outputs by state:
  - `busy` = (state ≠ IDLE).
  - `flush` = 1 in REDIRECT and FLUSH.
- Inputs `id_valid`, `branch`, `id_pc` and `id_offset` are ignored while `busy`=1. No second branch is queued.
- Counters saturate at all-ones and never wrap.
- `bad_code` clears only on reset.
- Reset values: state IDLE, `redirect_valid`=0, `redirect_pc`=0, `flush`=0, `busy`=0, both counters 0, `bad_code`=0.
- Reset asserted mid-operation (REDIRECT or FLUSH) returns everything to reset values immediately, asynchronously. No redirect is retained.

## Timing
- Taken branch sampled at edge T:
  - From T+1: `redirect_valid`=1, `flush`=1, `busy`=1.
  - From T+1: `taken_cnt` shows the increment.
- Redirect accepted at edge A (`redirect_ready`=1):
  - `redirect_valid` drops at A+1.
  - `flush` stays high through A+`FLUSH_CYCLES`.
  - `busy` is 0 from A+`FLUSH_CYCLES`+1.
- Minimum occupancy with `redirect_ready` tied high: 1 + `FLUSH_CYCLES` cycles.
- `redirect_ready` may be high before `redirect_valid`. Acceptance occurs only on an edge where both are high.
- Not-taken and reserved outcomes update `not_taken_cnt` / `bad_code` one cycle after the sampling edge. They never assert `busy`.
- Back-to-back taken branches: the second is accepted on the first IDLE cycle after the first completes.

## Structure
- Shared package `cpu_pkg` holds:
  - Branch-code constants `BR_NONE`, `BR_NOT_TAKEN`, `BR_TAKEN`, `BR_RSVD`.
  - Branch opcodes `OP_BGT`=4'b0100, `OP_BLT`=4'b0101, `OP_BEQ`=4'b0110.
  - The redirect FSM state encoding.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst_n`, `inc`, `count`) is instantiated twice, once per statistics counter.

## Test plan
- Not-taken: reset, then `id_valid`=1, `branch`=01 for 3 cycles:
  - `not_taken_cnt`=3.
  - `busy`, `flush` and `redirect_valid` stay 0.
- Taken with immediate accept: `id_pc`=16'h0040, `id_offset`=8'h05, `branch`=10, `redirect_ready` tied 1:
  - `redirect_pc`=16'h004C.
  - `redirect_valid` high 1 cycle.
  - `flush` high 3 cycles.
  - `taken_cnt`=1.
- Backward taken with held ready: `id_pc`=16'h0004, `id_offset`=8'hFC; `redirect_ready` low 4 cycles, then high:
  - `redirect_pc`=16'hFFFE (wrap).
  - `redirect_valid` and `redirect_pc` are stable for all 5 cycles.
  - A second branch presented meanwhile is ignored; `taken_cnt`=1.
- Reserved code: `branch`=11 with `id_valid`=1:
  - `bad_code`=1 and stays 1 through 10 following cycles.
  - Both counters are unchanged.
- Reset mid-operation: assert `rst_n`=0 while in FLUSH:
  - All outputs return to 0 without waiting for a clock edge.
  - The next taken branch behaves as in the immediate-accept scenario.
- Saturation: run with `CNT_W`=2 and 5 taken branches:
  - `taken_cnt` holds at 3.
  - No further increments occur.
